// File: rtl/life_gen_sequencer.sv
// ---------------------------------------------------------------------------
// life_gen_sequencer
//
// Owns the 8x8 Game-of-Life grid shown on the LED matrix. On each frame tick
// it walks the 64 cells one per clock through a single shared neighbour-count
// datapath, building the next generation in a separate buffer. The new
// generation is committed only while the LED driver is idle, so the displayed
// grid never changes in the middle of a shift-out.
//
// Cell addressing: bit index = row*8 + col, row = idx[5:3], col = idx[2:0].
//
// Parameters:
//   SEED    grid value after reset
//   WRAP    1 = toroidal edges, 0 = cells outside the 8x8 area are dead
//   DROP_W  width of the saturating dropped-tick counter
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   frame_tick    one-cycle pulse requesting the next generation
//   load_valid    request to overwrite the grid with load_grid (IDLE only)
//   load_grid     seed pattern to load
//   load_ready    high while a load would be accepted (state IDLE)
//   display_busy  LED driver is shifting out grid; commit must wait
//   grid          currently displayed generation
//   busy          high while computing or waiting to commit
//   gen_done      one-cycle pulse on the commit edge
//   gen_count     generations since reset/load, wraps at 16 bits
//   stable        last committed generation equalled its predecessor
//   dropped       frame ticks ignored (busy or pre-empted by a load), saturating
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module life_gen_sequencer #(
   parameter logic [63:0] SEED   = 64'h0000_0000_0000_0E00,
   parameter bit          WRAP   = 1'b1,
   parameter int          DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_tick,
   input  logic              load_valid,
   input  logic [63:0]       load_grid,
   output logic              load_ready,
   input  logic              display_busy,
   output logic [63:0]       grid,
   output logic              busy,
   output logic              gen_done,
   output logic [15:0]       gen_count,
   output logic              stable,
   output logic [DROP_W-1:0] dropped
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_COMMIT  = 2'd2
   } state_e;

   state_e              state_q,     state_d;
   logic [5:0]          idx_q,       idx_d;
   logic [63:0]         grid_q,      grid_d;
   logic [63:0]         next_q,      next_d;
   logic [15:0]         gen_count_q, gen_count_d;
   logic                stable_q,    stable_d;
   logic [DROP_W-1:0]   dropped_q,   dropped_d;
   logic                gen_done_q,  gen_done_d;
   logic                busy_q,      busy_d;

   logic [3:0]          nbr_cnt;
   logic                next_bit;
   logic                drop_tick;

   // ------------------------------------------------------------------------
   // Shared neighbour-count datapath for the cell selected by idx_q. Counts
   // always come from the committed grid, never from the partially built
   // next buffer, so every cell sees the same previous generation.
   // ------------------------------------------------------------------------
   always_comb begin
      logic [2:0] row;
      logic [2:0] col;
      logic [2:0] nr;
      logic [2:0] nc;
      logic       in_area;

      // NOTE: every variable assigned in a combinational block gets a default
      // at the top; a path that leaves one unassigned would infer a latch.
      nbr_cnt = 4'd0;
      row     = idx_q[5:3];
      col     = idx_q[2:0];
      nr      = 3'd0;
      nc      = 3'd0;
      in_area = 1'b0;

      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
               // 3-bit addition wraps modulo 8, which is exactly the toroidal
               // neighbour; without WRAP the edge-crossing cases are masked.
               nr = row + 3'(dr);
               nc = col + 3'(dc);
               in_area = WRAP ||
                         (!(dr == -1 && row == 3'd0) && !(dr == 1 && row == 3'd7) &&
                          !(dc == -1 && col == 3'd0) && !(dc == 1 && col == 3'd7));
               if (in_area) begin
                  nbr_cnt = nbr_cnt + 4'(grid_q[{nr, nc}]);
               end
            end
         end
      end

      // B3/S23: birth on exactly 3, survival on 2 or 3.
      next_bit = (nbr_cnt == 4'd3) || (grid_q[idx_q] && nbr_cnt == 4'd2);
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath control.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      grid_d      = grid_q;
      next_d      = next_q;
      gen_count_d = gen_count_q;
      stable_d    = stable_q;
      dropped_d   = dropped_q;
      gen_done_d  = 1'b0;
      drop_tick   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load_valid) begin
               // A load pre-empts a same-cycle tick; that tick counts as dropped.
               grid_d      = load_grid;
               gen_count_d = 16'd0;
               stable_d    = 1'b0;
               drop_tick   = frame_tick;
            end else if (frame_tick) begin
               idx_d   = 6'd0;
               state_d = ST_COMPUTE;
            end
         end

         ST_COMPUTE: begin
            drop_tick      = frame_tick;
            next_d[idx_q]  = next_bit;
            idx_d          = idx_q + 6'd1;
            if (idx_q == 6'd63) begin
               state_d = ST_COMMIT;
            end
         end

         ST_COMMIT: begin
            drop_tick = frame_tick;
            if (!display_busy) begin
               grid_d      = next_q;
               stable_d    = (next_q == grid_q);
               gen_count_d = gen_count_q + 16'd1;
               gen_done_d  = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (drop_tick && (dropped_q != {DROP_W{1'b1}})) begin
         dropped_d = dropped_q + DROP_W'(1);
      end

      // busy is registered alongside the state so it is glitch-free.
      busy_d = (state_d != ST_IDLE);
   end

   // ------------------------------------------------------------------------
   // State registers. Reset aborts any generation in flight and discards the
   // partial next buffer.
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= 6'd0;
         grid_q      <= SEED;
         next_q      <= 64'd0;
         gen_count_q <= 16'd0;
         stable_q    <= 1'b0;
         dropped_q   <= '0;
         gen_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         grid_q      <= grid_d;
         next_q      <= next_d;
         gen_count_q <= gen_count_d;
         stable_q    <= stable_d;
         dropped_q   <= dropped_d;
         gen_done_q  <= gen_done_d;
         busy_q      <= busy_d;
      end
   end

   assign load_ready = (state_q == ST_IDLE);
   assign grid       = grid_q;
   assign busy       = busy_q;
   assign gen_done   = gen_done_q;
   assign gen_count  = gen_count_q;
   assign stable     = stable_q;
   assign dropped    = dropped_q;

endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
- Owns the 8x8 Game-of-Life grid shown on the LED matrix. Computes one generation per frame tick using a single shared per-cell neighbour-count datapath, stepping through the cells one per clock.
- Commits the new generation only when the LED display driver is idle. The grid never changes mid-shift-out.
- Sits between the frame-rate timer (newframe) and the WS2812 driver inside top. Its grid output is the debug_grid the bench prints.

Parameters:
- SEED, 64'h0000_0000_0000_0E00, grid value after reset (bit index = row*8+col).
- WRAP, 1, 1 = toroidal edges; 0 = cells outside the 8x8 area count as dead.
- DROP_W, 8, width of the saturating dropped-tick counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse requesting the next generation (newframe)
- load_valid  in  1  request to overwrite the grid with load_grid
- load_grid  in  64  seed pattern, bit row*8+col
- load_ready  out  1  high when a load is accepted (state IDLE)
- display_busy  in  1  LED driver is shifting out grid; no commit allowed
- grid  out  64  current displayed generation
- busy  out  1  high in COMPUTE or COMMIT
- gen_done  out  1  one-cycle pulse on the commit edge
- gen_count  out  16  generations since reset/load, wraps 0xFFFF->0
- stable  out  1  last committed generation equalled its predecessor
- dropped  out  DROP_W  frame_ticks ignored while busy, saturating

Behaviour:
- Reset (async, rst_n=0):
  - grid=SEED, next buffer=0, idx=0, state=IDLE.
  - gen_count=0, stable=0, dropped=0, gen_done=0, busy=0, load_ready=1.
- States: IDLE, COMPUTE, COMMIT.
- IDLE:
  - load_valid=1: grid<=load_grid, gen_count<=0, stable<=0, stay IDLE. Load has priority over a same-cycle frame_tick; that tick is dropped and counted.
  - Else frame_tick=1: idx<=0, go to COMPUTE.
- COMPUTE: each cycle evaluates cell idx.
  - Row = idx[5:3], col = idx[2:0]; neighbour count 0..8 is taken from grid (never from the partial next buffer).
  - WRAP=1: neighbour coordinates taken mod 8. WRAP=0: out-of-range neighbours = 0.
  - Rule B3/S23: next[idx] = (cnt==3) | (grid[idx] & cnt==2).
  - idx increments each cycle; after idx=63, go to COMMIT. COMPUTE therefore lasts exactly 64 cycles.
- COMMIT:
  - If display_busy=1: hold, with grid and next buffer unchanged.
  - Else, on that edge: grid<=next, stable<=(next==grid), gen_count<=gen_count+1, gen_done=1 for one cycle, go to IDLE.
- Latency: a tick sampled in IDLE at edge T with display_busy=0 gives grid updated and gen_done high after edge T+65.
- frame_tick in COMPUTE or COMMIT is ignored; dropped increments, saturating at 2^DROP_W-1.
- load_valid outside IDLE is ignored and not counted. load_ready=0 in those states.
- grid is stable except on the commit edge or a load.
- busy = (state != IDLE), registered with the state.
- Reset asserted mid-COMPUTE or mid-COMMIT aborts immediately; the partial next buffer is discarded.

Test Plan:
- Blinker: reset with SEED=64'h0E00, one frame_tick, display_busy=0 -> after 65 cycles grid=64'h0000_0000_0004_0404, gen_count=1, stable=0; second tick -> grid=64'h0E00, gen_count=2.
- Still life:
  - Load 64'h0303, then tick -> grid stays 64'h0303, stable=1, gen_done pulses once.
  - Load 0 -> grid=0, stable=1 after one tick.
- Wrap: load 64'h83.
  - WRAP=1, tick -> grid=64'h0100_0000_0000_0101.
  - WRAP=0, same stimulus -> grid=0.
- Display hold: display_busy=1 from tick through cycle 100 -> grid unchanged, busy=1 until display_busy falls. Commit and gen_done on the first edge with display_busy=0.
- Overrun/priority:
  - Three extra frame_ticks during COMPUTE -> dropped=3, only one generation committed.
  - load_valid together with frame_tick in IDLE -> load wins, dropped increments, no COMPUTE entered.
- Reset mid-operation: drop rst_n at COMPUTE idx=30 -> grid=SEED, gen_count=0, state IDLE, busy=0 immediately (asynchronous, no clock edge needed).
